// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module : multicycle_ctrl_pkg
// Brief  : Shared state encodings, word width and latched-control record.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

  localparam int WORD_W  = 32;
  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t c_st_idle    = 3'd0;
  localparam state_t c_st_fetch   = 3'd1;
  localparam state_t c_st_decode  = 3'd2;
  localparam state_t c_st_execute = 3'd3;
  localparam state_t c_st_mem     = 3'd4;
  localparam state_t c_st_wb      = 3'd5;
  localparam state_t c_st_halt    = 3'd6;

  typedef struct packed {
    logic uncondbranch;
    logic branch;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  function automatic logic is_wait_state(input state_t s);
    return (s == c_st_fetch) || (s == c_st_mem);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module : multicycle_ctrl_if
// Brief  : Decode/memory handshake and status bundle around the controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = WORD_W
) ();

  logic             run;
  logic             imem_ack;
  logic             dmem_ack;
  logic             uncondbranch;
  logic             branch;
  logic             mem_read;
  logic             mem_write;
  logic             halt_instr;
  logic             zero;

  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_en;
  logic             rf_we;
  logic             pc_en;
  logic             pc_src;
  state_t           state;
  logic             busy;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  run, imem_ack, dmem_ack, uncondbranch, branch, mem_read,
           mem_write, halt_instr, zero,
    output imem_req, dmem_req, dmem_we, ir_en, rf_we, pc_en, pc_src,
           state, busy, halted, fault, retired
  );

  modport master (
    output run, imem_ack, dmem_ack, uncondbranch, branch, mem_read,
           mem_write, halt_instr, zero,
    input  imem_req, dmem_req, dmem_we, ir_en, rf_we, pc_en, pc_src,
           state, busy, halted, fault, retired
  );

endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_ack_timer.sv
// ============================================================================
// Module : ack_timer
// Brief  : Counts unacknowledged wait cycles; expired on the LIMIT-th cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ack_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int c_cnt_w = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(LIMIT - 1);

  logic [c_cnt_w-1:0] r_count;

  // Count holds 0 in the first wait cycle, so it equals LIMIT-1 in the LIMIT-th.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (tick && (r_count != c_last)) begin
      r_count <= r_count + c_cnt_w'(1);
    end
  end

  assign expired = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : Multicycle CPU control FSM with ack timeout and retire counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = WORD_W
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_if.slave      bus
);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  state_t           r_state;
  state_t           w_next_state;
  ctrl_t            r_ctrl;
  logic             r_stop;
  logic             r_fault;
  logic [CNT_W-1:0] r_retired;

  logic             w_waiting;
  logic             w_ack;
  logic             w_expired;
  logic             w_timeout;
  logic             w_branchy;
  logic             w_busy;
  state_t           w_boundary;

  logic w_imem_req, w_dmem_req, w_dmem_we, w_ir_en, w_rf_we, w_pc_en, w_pc_src;

  // Assertion is immediate; release reaches the FSM only after two clock edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_waiting  = is_wait_state(r_state);
  assign w_ack      = (r_state == c_st_fetch) ? bus.imem_ack : bus.dmem_ack;
  assign w_timeout  = w_waiting && !w_ack && w_expired;
  assign w_branchy  = r_ctrl.uncondbranch || r_ctrl.branch;
  assign w_busy     = (r_state != c_st_idle) && (r_state != c_st_halt);
  assign w_boundary = (r_stop || !bus.run) ? c_st_idle : c_st_fetch;

  ack_timer #(
    .LIMIT   (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .clear   (w_next_state != r_state),
    .tick    (w_waiting && !w_ack),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:    if (bus.run) w_next_state = c_st_fetch;
      c_st_fetch: begin
        if (bus.imem_ack)  w_next_state = c_st_decode;
        else if (w_expired) w_next_state = c_st_halt;
      end
      c_st_decode:  w_next_state = bus.halt_instr ? c_st_halt : c_st_execute;
      c_st_execute: begin
        if (w_branchy) w_next_state = w_boundary;
        else if (r_ctrl.mem_read || r_ctrl.mem_write) w_next_state = c_st_mem;
        else w_next_state = c_st_wb;
      end
      c_st_mem: begin
        if (bus.dmem_ack)   w_next_state = r_ctrl.mem_read ? c_st_wb : w_boundary;
        else if (w_expired) w_next_state = c_st_halt;
      end
      c_st_wb:      w_next_state = w_boundary;
      c_st_halt:    w_next_state = c_st_halt;
      default:      w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    w_imem_req = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;
    w_ir_en    = 1'b0;
    w_rf_we    = 1'b0;
    w_pc_en    = 1'b0;
    w_pc_src   = 1'b0;
    case (r_state)
      c_st_fetch: begin
        w_imem_req = 1'b1;
        w_ir_en    = bus.imem_ack;
      end
      c_st_execute: begin
        w_pc_en  = w_branchy;
        w_pc_src = r_ctrl.uncondbranch || (r_ctrl.branch && bus.zero);
      end
      c_st_mem: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = r_ctrl.mem_write;
        w_pc_en    = bus.dmem_ack && !r_ctrl.mem_read;
      end
      c_st_wb: begin
        w_rf_we = 1'b1;
        w_pc_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Controls are sampled only while leaving DECODE; EXECUTE/MEM see the snapshot.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ctrl    <= '0;
      r_stop    <= 1'b0;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      if (r_state == c_st_decode) begin
        r_ctrl <= '{uncondbranch: bus.uncondbranch, branch: bus.branch,
                    mem_read: bus.mem_read, mem_write: bus.mem_write};
      end
      if (r_state == c_st_idle) begin
        r_stop <= 1'b0;
      end else if (w_busy && !bus.run) begin
        r_stop <= 1'b1;
      end
      if (w_timeout) begin
        r_fault <= 1'b1;
      end
      if (w_pc_en) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign bus.imem_req = w_imem_req;
  assign bus.dmem_req = w_dmem_req;
  assign bus.dmem_we  = w_dmem_we;
  assign bus.ir_en    = w_ir_en;
  assign bus.rf_we    = w_rf_we;
  assign bus.pc_en    = w_pc_en;
  assign bus.pc_src   = w_pc_src;
  assign bus.state    = r_state;
  assign bus.busy     = w_busy;
  assign bus.halted   = (r_state == c_st_halt);
  assign bus.fault    = r_fault;
  assign bus.retired  = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Vector table with scoreboard for the main instance; timeout and
//          counter-wrap sequences on a small-parameter instance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a = 1'b0;
  logic reset_b = 1'b0;

  multicycle_ctrl_if #(.CNT_W(32)) bus_a ();
  multicycle_ctrl_if #(.CNT_W(4))  bus_b ();

  multicycle_ctrl #(.ACK_TIMEOUT(255), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.slave)
  );

  multicycle_ctrl #(.ACK_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.slave)
  );

  typedef struct packed {
    logic rst; logic run; logic iack; logic dack; logic unc;
    logic br;  logic mrd; logic mwr;  logic hlt;  logic zero;
  } in_t;

  typedef struct packed {
    logic [2:0] st;
    logic imreq; logic dmreq; logic dwe; logic iren; logic rfwe; logic pcen; logic pcsrc;
    logic busy;  logic hltd;  logic flt;
  } out_t;

  typedef struct { int id; in_t in; out_t exp; logic [31:0] ret; } vec_t;
  typedef struct { int id; out_t exp; logic [31:0] ret; } sb_t;

  localparam logic [9:0] c_rst  = 10'h200, c_run = 10'h100, c_iack = 10'h080,
                         c_dack = 10'h040, c_unc = 10'h020, c_br   = 10'h010,
                         c_mrd  = 10'h008, c_mwr = 10'h004, c_hlt  = 10'h002,
                         c_zero = 10'h001;
  localparam logic [6:0] c_ireq = 7'h40, c_dreq = 7'h20, c_dwe  = 7'h10, c_iren = 7'h08,
                         c_rfwe = 7'h04, c_pcen = 7'h02, c_pcsrc = 7'h01;

  vec_t        tbl[$];
  sb_t         sb[$];
  int          b_id;
  logic [31:0] b_ret;
  int          n_vec = 0;
  int          n_err = 0;

  // Expected retire count follows the expected pc_en pulses; reset zeroes it.
  task automatic add(input logic [9:0] in, input state_t st, input logic [6:0] strb);
    vec_t v;
    if (in[9]) b_ret = 32'd0;
    v.id  = b_id;
    v.in  = in;
    v.exp = {st, strb, (st != c_st_idle) && (st != c_st_halt), (st == c_st_halt), 1'b0};
    v.ret = b_ret;
    tbl.push_back(v);
    if ((strb & c_pcen) != 7'd0) b_ret = b_ret + 32'd1;
  endtask

  task automatic fetch_ack();
    add(c_run | c_iack, c_st_fetch, c_ireq | c_iren);
  endtask

  task automatic drive_a(input in_t i);
    reset_a            = ~i.rst;
    bus_a.run          = i.run;
    bus_a.imem_ack     = i.iack;
    bus_a.dmem_ack     = i.dack;
    bus_a.uncondbranch = i.unc;
    bus_a.branch       = i.br;
    bus_a.mem_read     = i.mrd;
    bus_a.mem_write    = i.mwr;
    bus_a.halt_instr   = i.hlt;
    bus_a.zero         = i.zero;
  endtask

  task automatic check_a();
    sb_t  e;
    out_t got;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e   = sb.pop_front();
      got = {bus_a.state, bus_a.imem_req, bus_a.dmem_req, bus_a.dmem_we, bus_a.ir_en,
             bus_a.rf_we, bus_a.pc_en, bus_a.pc_src, bus_a.busy, bus_a.halted, bus_a.fault};
      if (got !== e.exp || bus_a.retired !== e.ret) begin
        n_err++;
        $display("FAIL seq%0d: got out=%b retired=%0d, expected out=%b retired=%0d",
                 e.id, got, bus_a.retired, e.exp, e.ret);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic b_inputs_clear();
    bus_b.run = 1'b0; bus_b.imem_ack = 1'b0; bus_b.dmem_ack = 1'b0;
    bus_b.uncondbranch = 1'b0; bus_b.branch = 1'b0; bus_b.mem_read = 1'b0;
    bus_b.mem_write = 1'b0; bus_b.halt_instr = 1'b0; bus_b.zero = 1'b0;
  endtask

  // Leaves instance B in IDLE with run=1 applied, sampled in its first FETCH cycle.
  task automatic b_restart_to_fetch(input string name);
    @(negedge clk); reset_b = 1'b0; b_inputs_clear();
    @(negedge clk);
    @(negedge clk); reset_b = 1'b1;
    repeat (3) @(negedge clk);
    #2 chk({name, "_idle"}, {29'd0, bus_b.state}, {29'd0, c_st_idle});
    @(negedge clk); bus_b.run = 1'b1;
    for (int g = 0; g < 10 && bus_b.state != c_st_fetch; g++) begin
      @(negedge clk); #2;
    end
    chk({name, "_fetch"}, {29'd0, bus_b.state}, {29'd0, c_st_fetch});
  endtask

  // Called at a sample point inside FETCH; returns at the next FETCH sample point.
  task automatic b_branch_instr();
    chk("b_br_fetch", {29'd0, bus_b.state}, {29'd0, c_st_fetch});
    bus_b.imem_ack = 1'b1;
    @(negedge clk); bus_b.imem_ack = 1'b0; bus_b.uncondbranch = 1'b1;
    @(negedge clk); bus_b.uncondbranch = 1'b0;
    #2 chk("b_br_pcen", {30'd0, bus_b.pc_en, bus_b.pc_src}, 32'd3);
    @(negedge clk); #2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_req;
    drive_a('0);
    reset_a = 1'b0;
    b_inputs_clear();
    b_ret = 32'd0;

    // ---------------- vector table for instance A ----------------
    b_id = 0;
    add(c_rst, c_st_idle, 7'd0);
    add(c_rst, c_st_idle, 7'd0);
    repeat (3) add(10'd0, c_st_idle, 7'd0);

    b_id = 1;  // ALU op, ack on third FETCH cycle, stray acks ignored
    add(c_run, c_st_idle, 7'd0);
    add(c_run, c_st_fetch, c_ireq);
    add(c_run, c_st_fetch, c_ireq);
    fetch_ack();
    add(c_run | c_dack, c_st_decode, 7'd0);
    add(c_run | c_iack | c_mrd | c_br, c_st_execute, 7'd0);
    add(c_run, c_st_wb, c_rfwe | c_pcen);

    b_id = 2;  // taken branch, input dropped after DECODE
    fetch_ack();
    add(c_run | c_br, c_st_decode, 7'd0);
    add(c_run | c_zero, c_st_execute, c_pcen | c_pcsrc);

    b_id = 3;  // branch not taken
    fetch_ack();
    add(c_run | c_br, c_st_decode, 7'd0);
    add(c_run | c_br, c_st_execute, c_pcen);

    b_id = 4;  // unconditional branch ignores zero
    fetch_ack();
    add(c_run | c_unc, c_st_decode, 7'd0);
    add(c_run, c_st_execute, c_pcen | c_pcsrc);

    b_id = 5;  // load, dmem_ack in fifth MEM cycle
    fetch_ack();
    add(c_run | c_mrd, c_st_decode, 7'd0);
    add(c_run, c_st_execute, 7'd0);
    repeat (4) add(c_run, c_st_mem, c_dreq);
    add(c_run | c_dack, c_st_mem, c_dreq);
    add(c_run, c_st_wb, c_rfwe | c_pcen);

    b_id = 6;  // store retires from MEM, no register write
    fetch_ack();
    add(c_run | c_mwr, c_st_decode, 7'd0);
    add(c_run, c_st_execute, 7'd0);
    add(c_run | c_iack, c_st_mem, c_dreq | c_dwe);
    add(c_run | c_dack, c_st_mem, c_dreq | c_dwe | c_pcen);

    b_id = 7;  // branch wins over memory controls
    fetch_ack();
    add(c_run | c_br | c_mrd | c_mwr, c_st_decode, 7'd0);
    add(c_run | c_zero, c_st_execute, c_pcen | c_pcsrc);

    b_id = 8;  // run dropped in MEM: finish load, park in IDLE, then resume
    fetch_ack();
    add(c_run | c_mrd, c_st_decode, 7'd0);
    add(c_run, c_st_execute, 7'd0);
    add(10'd0, c_st_mem, c_dreq);
    add(c_dack, c_st_mem, c_dreq);
    add(10'd0, c_st_wb, c_rfwe | c_pcen);
    add(10'd0, c_st_idle, 7'd0);
    add(10'd0, c_st_idle, 7'd0);
    add(c_run, c_st_idle, 7'd0);

    b_id = 9;  // reset asserted mid-MEM
    add(c_run, c_st_fetch, c_ireq);
    fetch_ack();
    add(c_run | c_mwr, c_st_decode, 7'd0);
    add(c_run, c_st_execute, 7'd0);
    add(c_run, c_st_mem, c_dreq | c_dwe);
    add(c_run | c_rst, c_st_idle, 7'd0);
    add(c_rst, c_st_idle, 7'd0);
    repeat (3) add(10'd0, c_st_idle, 7'd0);

    b_id = 10; // halt instruction wins over all other controls
    add(c_run, c_st_idle, 7'd0);
    fetch_ack();
    add(c_run | c_hlt | c_br | c_unc | c_mrd, c_st_decode, 7'd0);
    add(c_run | c_iack | c_dack, c_st_halt, 7'd0);
    add(c_run, c_st_halt, 7'd0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive_a(tbl[k].in);
      sb.push_back('{id: tbl[k].id, exp: tbl[k].exp, ret: tbl[k].ret});
      #2;
      check_a();
    end

    // ---------------- instance B: imem_ack never arrives ----------------
    b_restart_to_fetch("tmo");
    n_req = 0;
    for (int g = 0; g < 20 && bus_b.state != c_st_halt; g++) begin
      if (bus_b.imem_req) n_req++;
      @(negedge clk); #2;
    end
    chk("tmo_state", {29'd0, bus_b.state}, {29'd0, c_st_halt});
    chk("tmo_fetch_cycles", n_req, 32'd4);
    chk("tmo_flags", {28'd0, bus_b.fault, bus_b.halted, bus_b.busy, bus_b.imem_req}, 32'hC);

    // ---------------- instance B: ack on the timeout cycle ----------------
    b_restart_to_fetch("late");
    repeat (3) @(negedge clk);
    bus_b.imem_ack = 1'b1;
    #2 chk("late_ir_en", {31'd0, bus_b.ir_en}, 32'd1);
    @(negedge clk); bus_b.imem_ack = 1'b0;
    #2 chk("late_decode", {28'd0, bus_b.fault, bus_b.state}, {28'd0, 1'b0, c_st_decode});
    @(negedge clk); #2;
    @(negedge clk); #2 chk("late_wb", {31'd0, bus_b.rf_we}, 32'd1);
    @(negedge clk); #2 chk("late_retired", {28'd0, bus_b.retired}, 32'd1);

    // ---------------- instance B: retire counter wraps ----------------
    for (int n = 0; n < 14; n++) b_branch_instr();
    chk("wrap_max", {28'd0, bus_b.retired}, 32'hF);
    b_branch_instr();
    chk("wrap_zero", {27'd0, bus_b.fault, bus_b.retired}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255: maximum cycles a memory request may wait for ack before a fault.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
REQ-006 imem_ack, dmem_ack  in  1 each  memory completion strobes, one cycle each.
REQ-007 uncondbranch, branch, mem_read, mem_write, halt_instr  in  1 each  decoded controls from the decode stage.
REQ-008 zero  in  1  ALU zero flag, valid in EXECUTE.
REQ-009 imem_req, dmem_req, dmem_we  out  1 each  memory request/write-enable, held until ack.
REQ-010 ir_en, rf_we, pc_en, pc_src  out  1 each  instruction-register load, register-file write, PC update, PC select (1 = branch_target).
REQ-011 state  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6.
REQ-012 busy, halted, fault  out  1 each  status flags.
REQ-013 retired  out  CNT_W  count of completed instructions.

Function
REQ-014 IDLE: all strobes 0; run=1 -> FETCH on the next edge.
REQ-015 FETCH: imem_req=1 until imem_ack; on ack, ir_en=1 for that cycle and the next state is DECODE.
REQ-016 DECODE: one cycle; uncondbranch, branch, mem_read, mem_write and halt_instr latch at the DECODE->EXECUTE edge; later input changes are ignored until the next DECODE.
REQ-017 DECODE with halt_instr=1 -> HALT; halt takes priority over every other control.
REQ-018 EXECUTE, latched branch or uncondbranch: pc_en=1, pc_src = uncondbranch | (branch & zero), retire, -> FETCH.
REQ-019 EXECUTE, latched mem_read or mem_write -> MEM; otherwise -> WB.
REQ-020 If both branch and mem controls are latched, the branch path wins.
REQ-021 MEM: dmem_req=1 and dmem_we=latched mem_write until dmem_ack.
REQ-022 MEM on ack: if mem_read -> WB; if store-only, pc_en=1, pc_src=0, retire, -> FETCH.
REQ-023 WB: rf_we=1, pc_en=1, pc_src=0 for exactly one cycle, retire, -> FETCH.
REQ-024 Retire = retired+1 in the cycle pc_en=1; the counter wraps from 2^CNT_W-1 to 0 without flagging.
REQ-025 Wait counter clears on entering FETCH or MEM and increments each cycle without ack.
REQ-026 Wait counter reaching ACK_TIMEOUT with no ack -> HALT with fault=1.
REQ-027 An ack in the same cycle as timeout wins: no fault.
REQ-028 run=0 sampled at any point completes the current instruction; the controller enters IDLE instead of FETCH at the next boundary, with no new imem_req.
REQ-029 run=1 in IDLE resumes at FETCH; retired is preserved.
REQ-030 HALT: all strobes 0, halted=1; exit only by reset.
REQ-031 busy=1 in every state except IDLE and HALT.
REQ-032 Strobes are Moore outputs of state plus latched controls plus the ack input; an ack arriving outside a waiting state is ignored.

Reset
REQ-033 reset=0 immediately forces state=IDLE; all outputs 0; retired=0; fault=0; wait counter=0; latched controls=0.
REQ-034 Reset asserted mid-MEM drops dmem_req in the same cycle with no retire.
REQ-035 Deassertion is synchronized to clk before the FSM leaves IDLE.

Structure
REQ-036 State encodings and the WORD width come from the shared definitions header; ACK_TIMEOUT stays a local parameter.
REQ-037 Wait/timeout counter is a sub-module ack_timer (inputs: clear, tick; output: expired).
REQ-038 Top-level datapath instantiates multicycle_ctrl alongside fetch and decode; no datapath logic lives in this block.

Verification
REQ-039 ALU op, run=1, imem_ack 2 cycles after req -> FETCH(3 cycles)-DECODE-EXECUTE-WB; one rf_we pulse; retired=1.
REQ-040 branch=1, zero=1 -> pc_en=1, pc_src=1 in EXECUTE, no rf_we; with zero=0 -> pc_src=0.
REQ-041 Load, dmem_ack after 5 cycles -> dmem_req high 5 cycles, dmem_we=0, WB follows; store -> dmem_we=1, no rf_we.
REQ-042 ACK_TIMEOUT=4, imem_ack never arrives -> HALT, fault=1, halted=1 after 4 FETCH cycles; ack on cycle 4 -> no fault.
REQ-043 Preload retired=2^32-1 via 2^32-1 retires (forced) and retire once -> retired=0.
REQ-044 run dropped in MEM -> instruction completes, IDLE entered, imem_req stays 0; reset pulse mid-MEM -> IDLE next, all outputs 0.
